// File: rtl/pipe_skid_latch.sv
// Pipeline-stage latch holding one payload plus valid, with an optional one-entry
// skid buffer so upstream ready is registered, plus flush and a saturating stall counter.
module pipe_skid_latch #(
    parameter int WIDTH   = 264,
    parameter int SKID_EN = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_v,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_ready,
    input  logic             stall,
    input  logic             flush,
    output logic             o_v,
    output logic [WIDTH-1:0] o_data,
    output logic [CNT_W-1:0] o_stall_cnt
);

    localparam bit SKID = (SKID_EN != 0);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        if (&val) begin
            return val;
        end
        return val + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic             mv_q, mv_d;
    logic [WIDTH-1:0] md_q, md_d;
    logic             sv_q, sv_d;
    logic [WIDTH-1:0] sd_q, sd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic accept;
    logic adv;

    assign o_ready     = SKID ? ~sv_q : ~stall;
    assign accept      = i_v & o_ready;
    assign adv         = ~stall | ~mv_q;
    assign o_v         = mv_q;
    assign o_data      = md_q;
    assign o_stall_cnt = cnt_q;

    always_comb begin
        mv_d  = mv_q;
        md_d  = md_q;
        sv_d  = sv_q;
        sd_d  = sd_q;
        cnt_d = cnt_q;

        if (mv_q && stall && !flush) begin
            cnt_d = sat_inc(cnt_q);
        end

        if (flush) begin
            mv_d = 1'b0;
            sv_d = 1'b0;
        end else if (!SKID) begin
            // Legacy latch: a bubble is captured just like a real entry.
            if (!stall) begin
                mv_d = i_v;
                md_d = i_data;
            end
        end else if (adv) begin
            if (sv_q) begin
                // Drain the older parked entry first; o_ready is low so nothing is accepted.
                mv_d = 1'b1;
                md_d = sd_q;
                sv_d = 1'b0;
            end else begin
                mv_d = accept;
                if (accept) begin
                    md_d = i_data;
                end
            end
        end else if (accept) begin
            sv_d = 1'b1;
            sd_d = i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mv_q  <= 1'b0;
            md_q  <= '0;
            sv_q  <= 1'b0;
            sd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mv_q  <= mv_d;
            md_q  <= md_d;
            sv_q  <= SKID ? sv_d : 1'b0;
            sd_q  <= SKID ? sd_d : sd_q;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: doc/pipe_skid_latch.md
Name: pipe_skid_latch

Overview:
- Parametrised pipeline-stage latch: successor to the fixed-width decode→register-read latch.
- Holds one stage's payload plus its valid bit between two pipeline stages.
- Adds an optional one-entry skid buffer, so upstream ready is a registered signal and is no longer combinationally tied to downstream stall.
- Adds flush (squash) support and a saturating stall-cycle performance counter.

Parameters:
- WIDTH, 264: payload width in bits. Valid travels separately, not inside the payload.
- SKID_EN, 1: 1 = elastic stage with a one-entry skid buffer; 0 = plain stall latch, legacy behaviour.
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  in  1  stage clock.
- rst  in  1  synchronous, active-high reset.
- i_v  in  1  upstream entry valid.
- i_data  in  WIDTH  upstream payload.
- o_ready  out  1  stage can accept an upstream entry this cycle.
- stall  in  1  downstream cannot consume o_data this cycle.
- flush  in  1  squash all held entries; drop any incoming entry.
- o_v  out  1  held entry valid.
- o_data  out  WIDTH  held payload.
- o_stall_cnt  out  CNT_W  count of cycles with o_v=1 and stall=1.

Behaviour:
- Storage:
  - Main register M: mv, md. o_v=mv, o_data=md.
  - Skid register S: sv, sd. Only present when SKID_EN=1.
- Reset (rst=1 at a clk edge): mv=0, sv=0, md=0, sd=0, o_stall_cnt=0. o_ready=1 from the first cycle after reset. Reset overrides flush and stall.
- Priority each cycle: rst > flush > normal operation.
- Flush:
  - Next cycle: mv=0, sv=0.
  - An i_v presented in the flush cycle is dropped.
  - md/sd values are don't-care and are not required to clear.
  - o_ready=1 in the cycle after a flush.
- SKID_EN=0 (legacy latch):
  - o_ready = ~stall (combinational).
  - When stall=0: mv<=i_v, md<=i_data.
  - When stall=1: hold. An upstream bubble is also held.
  - Latency: 1 cycle, in to out.
- SKID_EN=1 (elastic):
  - o_ready = ~sv. Registered, with no combinational path from stall.
  - accept = i_v & o_ready.
  - adv = ~stall | ~mv (M may be overwritten).
  - adv & sv: M<=S, sv<=0. No accept is possible, since o_ready=0.
  - adv & ~sv: mv<=accept. md<=i_data when accept, otherwise md holds.
  - ~adv & accept: S<=i_data, sv<=1. M holds.
  - ~adv & ~accept: hold everything.
  - Latency: 1 cycle when not stalled. An entry parked in S appears on o_data 1 cycle after stall deasserts.
  - Order is preserved: S is always younger than M.
  - Maximum 2 entries held. No entry is lost or duplicated.
- Upstream contract:
  - Upstream may change or withdraw i_data/i_v while o_ready=0.
  - An entry is transferred only on a cycle with i_v & o_ready.
- Stall counter:
  - Increments when mv & stall & ~flush.
  - Saturates at 2^CNT_W−1; no wrap.
  - Cleared only by rst.
- Throughput: 1 entry/cycle sustained when stall=0, in both modes.

Test Plan:
- Reset: hold rst 2 cycles with i_v=1, i_data=0x1234 → o_v=0, o_data=0, o_ready=1, o_stall_cnt=0. First accepted entry appears 1 cycle after rst drops.
- Streaming, SKID_EN=1: stall=0, send A=1,2,3,4 on consecutive cycles → o_data shows 1,2,3,4 on cycles 1–4 with o_v=1. o_ready stays 1 throughout.
- Skid fill/drain: M holds 5, stall=1, send 6 → S=6, o_ready=0 next cycle. Holding i_v=1 with i_data=7 for 3 cycles → 7 is not accepted and o_data stays 5. stall=0 → o_data=6 next cycle, o_ready=1 again, then 7 accepted.
- Flush priority: M=9, S=10, stall=1, flush=1, i_v=1 with data 11 → next cycle o_v=0, o_ready=1. 11 never appears. o_stall_cnt does not increment in the flush cycle.
- Legacy mode, SKID_EN=0: stall=1 for 2 cycles with i_v=1 → o_ready=0 and o_data holds. stall=0 → new entry loads the next cycle. A bubble (i_v=0) loaded gives o_v=0.
- Counter saturation: CNT_W=4, o_v=1, stall=1 for 20 cycles → o_stall_cnt reaches 15 and holds at 15. Cycles with o_v=0 and stall=1 do not count.
